iter_multdiv_unit: RTL and testbench

//  Iterative multiply/divide responder for the X stage of the 5-stage pipeline. Accepts a
//  one-cycle ctrl_MULT/ctrl_DIV start pulse plus operands from the processor, runs a

---
 rtl/iter_multdiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_iter_multdiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iter_multdiv_unit.sv
// ============================================================================
// Module   : iter_multdiv_unit
// Purpose  : Iterative signed multiply (shift-add) / divide (restoring) unit
//            with a one-cycle completion pulse. Optional macro
//            MULTDIV_EARLY_EXIT_EN finishes zero-operand cases in one step.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iter_multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] C_LAST_CNT   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_FINAL_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;
  logic [WIDTH-1:0]   quo_q,    quo_d;
  logic [WIDTH-1:0]   dvsr_q,   dvsr_d;
  logic               neg_q,    neg_d;
  logic               dz_q,     dz_d;
  logic               early_q,  early_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q,    exc_d;

  logic               w_start;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_early_mult;
  logic               w_early_div;
  logic [2*WIDTH-1:0] w_addend;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_rem_sub;
  logic               w_fits;
  logic [WIDTH-1:0]   w_quo_signed;
  logic               w_mul_exc;
  logic [WIDTH:0]     w_prod_hi;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

`ifdef MULTDIV_EARLY_EXIT_EN
  assign w_early_mult = (data_operandA == '0) | (data_operandB == '0);
  assign w_early_div  = (data_operandB == '0);
`else
  assign w_early_mult = 1'b0;
  assign w_early_div  = 1'b0;
`endif

  // The final multiplier bit carries negative weight in two's complement.
  assign w_addend = !mplier_q[0]              ? '0 :
                    (cnt_q == C_FINAL_ITER)   ? ('0 - mcand_q) : mcand_q;

  assign w_rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign w_fits    = (w_rem_sh >= {1'b0, dvsr_q});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - dvsr_q;

  assign w_quo_signed = neg_q ? (~quo_q + 1'b1) : quo_q;
  assign w_prod_hi    = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_mul_exc    = !((&w_prod_hi) | ~(|w_prod_hi));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a start pulse overrides whatever is in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_MULT,
      S_DIV:  if (early_q || (cnt_q == C_LAST_CNT)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ctrl_MULT)     state_d = S_MULT;
    else if (ctrl_DIV) state_d = S_DIV;
  end

  // Output logic
  always_comb begin
    data_resultRDY = (state_q == S_DONE);
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    early_d  = early_q;
    result_d = result_q;
    exc_d    = exc_q;

    if (w_start) begin
      cnt_d    = '0;
      mcand_d  = {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
      mplier_d = data_operandB;
      acc_d    = '0;
      rem_d    = '0;
      quo_d    = w_abs_a;
      dvsr_d   = w_abs_b;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz_d     = (data_operandB == '0);
      early_d  = ctrl_MULT ? w_early_mult : w_early_div;
    end else if ((state_q == S_MULT) && (cnt_q != C_LAST_CNT)) begin
      acc_d    = acc_q + w_addend;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end else if ((state_q == S_DIV) && (cnt_q != C_LAST_CNT)) begin
      rem_d    = w_fits ? w_rem_sub : w_rem_sh[WIDTH-1:0];
      quo_d    = {quo_q[WIDTH-2:0], w_fits};
      cnt_d    = cnt_q + 1'b1;
    end

    // Early exits see acc_q = 0 or dz_q = 1, so the normal finalize still applies.
    if (state_d == S_DONE) begin
      if (state_q == S_MULT) begin
        result_d = acc_q[WIDTH-1:0];
        exc_d    = w_mul_exc;
      end else if (dz_q) begin
        result_d = '0;
        exc_d    = 1'b1;
      end else begin
        result_d = w_quo_signed;
        exc_d    = quo_q[WIDTH-1] & ~neg_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      early_q  <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      early_q  <= early_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iter_multdiv_unit.sv
// ============================================================================
// Module   : tb_iter_multdiv_unit
// Purpose  : Directed and random checks of iter_multdiv_unit against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iter_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV  = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;

  iter_multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain signed arithmetic
  function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = int'($signed(a)) / int'($signed(b));
      r = q;
      e = 1'b0;
    end
  endfunction

  function automatic int latency(input bit m, input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_EARLY_EXIT_EN
    if (m && (a == 0 || b == 0)) return 1;
    if (!m && b == 0) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = $urandom_range(0, 40) - 20;
      4: v = $urandom_range(0, 32'hFFFF);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Wait for RDY after edge 0; returns the edge number it was seen at, 0 on timeout.
  task automatic wait_rdy(output int lat);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) lat = n;
    end
  endtask

  // Called at posedge+1; issues a start, scrambles inputs afterwards, checks everything.
  task automatic run_op(input bit m, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er;
    logic        ee;
    int          lat;
    model(m, a, b, er, ee);
    ctrl_MULT = m; ctrl_DIV = !m; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    wait_rdy(lat);
    chk({tag, "/lat"}, lat, latency(m, a, b));
    chk({tag, "/res"}, data_result, er);
    chk({tag, "/exc"}, data_exception, ee);
    @(posedge clock); #1;
    chk({tag, "/rdy_pulse"}, data_resultRDY, 1'b0);
    chk({tag, "/hold"}, data_result, er);
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic        m;
    logic [31:0] a, b;

    repeat (2) @(posedge clock);
    #1;
    chk("reset/res", data_result, 32'd0);
    chk("reset/exc", data_exception, 1'b0);
    chk("reset/rdy", data_resultRDY, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("idle/rdy", data_resultRDY, 1'b0);

    run_op(1'b1, 32'd7, -32'sd6, "mul_7x-6");
    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    run_op(1'b0, -32'sd7, 32'd2, "div_-7/2");
    run_op(1'b0, 32'd5, 32'd0, "div_by0");
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_min/-1");
    run_op(1'b1, 32'd0, 32'd1234, "mul_zero");
    run_op(1'b0, 32'h8000_0000, 32'd1, "div_min/1");

    // Abort: MULT 3x4, then DIV 100/10 sampled at edge 10
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    seen = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clock); #1;
      seen |= data_resultRDY;
    end
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd10;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
    wait_rdy(lat);
    chk("abort/early_rdy", seen, 1'b0);
    chk("abort/lat", lat, 33);
    chk("abort/res", data_result, 32'd10);
    chk("abort/exc", data_exception, 1'b0);

    // Reset in the middle of an operation
    @(posedge clock); #1;
    ctrl_MULT = 1'b1; data_operandA = 32'h1234; data_operandB = 32'd5;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset/res", data_result, 32'd0);
    chk("midreset/exc", data_exception, 1'b0);
    chk("midreset/rdy", data_resultRDY, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      seen |= data_resultRDY;
    end
    chk("midreset/no_rdy", seen, 1'b0);
    run_op(1'b1, 32'd2, 32'd3, "mul_2x3");

    // Random operations
    for (int i = 0; i < 24; i++) begin
      m = $urandom_range(0, 1);
      a = pick();
      b = pick();
      run_op(m, a, b, $sformatf("rand%0d_%s", i, m ? "mul" : "div"));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
